// File: rtl/img2col_col_feeder_if.sv
// Stream-in / global-bank-out bus of the img2col column feeder.
// The master modport is the feeder side. The slave modport is the upstream source together with the bank and PU controller.
interface img2col_col_feeder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_W     = 5
) ();
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;
  logic                  g_wr;
  logic [ADDR_W-1:0]     g_adrs;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  g_rd;

  modport master (
    input  s_valid, s_data, g_rd,
    output s_ready, g_wr, g_adrs, g_data
  );

  modport slave (
    output s_valid, s_data, g_rd,
    input  s_ready, g_wr, g_adrs, g_data
  );
endinterface

// File: rtl/img2col_col_feeder.sv
// Write-side producer for the img2col global column buffer.
// It fills ROWS words per column, waits for the PU read, and walks an image as stripes of IMG_W columns.
module img2col_col_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int ROWS       = 5,
  parameter int ADDR_W     = 5,
  parameter int IMG_W      = 32,
  parameter int STRIPE_W   = 8
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                start_i,
  input  logic [STRIPE_W-1:0] stripes_i,
  img2col_col_feeder_if.master bus,
  output logic [5:0]          round_o,
  output logic                pu_start_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  typedef enum logic [1:0] {IDLE, FILL, WAIT_RD, FIN} state_t;

  state_t                state_q;
  logic [ADDR_W-1:0]     row_q;
  logic [5:0]            col_q;
  logic [STRIPE_W-1:0]   stripe_q;
  logic [STRIPE_W-1:0]   stripes_q;
  logic                  s_ready_q;
  logic                  g_wr_q;
  logic [ADDR_W-1:0]     g_adrs_q;
  logic [DATA_WIDTH-1:0] g_data_q;
  logic                  pu_start_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;

  logic last_row;
  logic last_col;
  logic last_stripe;

  assign last_row    = (row_q == ADDR_W'(ROWS - 1));
  assign last_col    = (col_q == 6'(IMG_W - 1));
  assign last_stripe = (stripe_q == stripes_q - STRIPE_W'(1));

  // NOTE: all state and output registers use <= so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      stripe_q   <= '0;
      stripes_q  <= '0;
      s_ready_q  <= 1'b0;
      g_wr_q     <= 1'b0;
      g_adrs_q   <= '0;
      g_data_q   <= '0;
      pu_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      g_wr_q     <= 1'b0;
      pu_start_q <= 1'b0;
      done_q     <= 1'b0;

      case (state_q)
        IDLE: begin
          if (bus.g_rd) err_q <= 1'b1;
          if (start_i) begin
            if (stripes_i != '0) begin
              // An accepted start wins over a same-cycle stray g_rd, so err clears.
              stripes_q  <= stripes_i;
              row_q      <= '0;
              col_q      <= '0;
              stripe_q   <= '0;
              err_q      <= 1'b0;
              pu_start_q <= 1'b1;
              busy_q     <= 1'b1;
              s_ready_q  <= 1'b1;
              state_q    <= FILL;
            end else begin
              done_q <= 1'b1;
            end
          end
        end

        FILL: begin
          if (bus.g_rd) err_q <= 1'b1;
          if (bus.s_valid) begin
            g_wr_q   <= 1'b1;
            g_adrs_q <= row_q;
            g_data_q <= bus.s_data;
            if (last_row) begin
              row_q     <= '0;
              s_ready_q <= 1'b0;
              state_q   <= WAIT_RD;
            end else begin
              row_q <= row_q + ADDR_W'(1);
            end
          end
        end

        WAIT_RD: begin
          if (bus.g_rd) begin
            col_q <= last_col ? 6'd0 : col_q + 6'd1;
            // done is raised on entry so it is visible during the single FIN cycle.
            if (last_col && last_stripe) begin
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              if (last_col) stripe_q <= stripe_q + STRIPE_W'(1);
              s_ready_q <= 1'b1;
              state_q   <= FILL;
            end
          end
        end

        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.s_ready = s_ready_q;
  assign bus.g_wr    = g_wr_q;
  assign bus.g_adrs  = g_adrs_q;
  assign bus.g_data  = g_data_q;
  assign round_o     = col_q;
  assign pu_start_o  = pu_start_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_img2col_col_feeder.sv
// Directed bench for img2col_col_feeder with a write scoreboard.
// dut_a uses IMG_W=3 and dut_b uses IMG_W=1.
module tb_img2col_col_feeder;

  localparam int DW      = 16;
  localparam int AW      = 5;
  localparam int ROWS    = 5;
  localparam int IMG_W_A = 3;

  typedef struct packed {
    logic [AW-1:0] adrs;
    logic [DW-1:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       nrst;
  logic       a_start, b_start;
  logic [7:0] a_stripes, b_stripes;
  logic [5:0] a_round, b_round;
  logic       a_pu_start, a_busy, a_done, a_err;
  logic       b_pu_start, b_busy, b_done, b_err;

  img2col_col_feeder_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) a_if ();
  img2col_col_feeder_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) b_if ();

  img2col_col_feeder #(.DATA_WIDTH(DW), .ROWS(ROWS), .ADDR_W(AW), .IMG_W(IMG_W_A), .STRIPE_W(8)) dut_a (
    .clk(clk), .nrst(nrst), .start_i(a_start), .stripes_i(a_stripes), .bus(a_if.master),
    .round_o(a_round), .pu_start_o(a_pu_start), .busy_o(a_busy), .done_o(a_done), .err_o(a_err)
  );

  img2col_col_feeder #(.DATA_WIDTH(DW), .ROWS(ROWS), .ADDR_W(AW), .IMG_W(1), .STRIPE_W(8)) dut_b (
    .clk(clk), .nrst(nrst), .start_i(b_start), .stripes_i(b_stripes), .bus(b_if.master),
    .round_o(b_round), .pu_start_o(b_pu_start), .busy_o(b_busy), .done_o(b_done), .err_o(b_err)
  );

  always #5 clk = ~clk;

  int  vectors     = 0;
  int  miscompares = 0;
  int  a_wr_cnt    = 0;
  int  exp_row     = 0;
  wr_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pops one expected entry for every observed write on dut_a.
  always @(posedge clk) begin
    #1;
    if (a_if.g_wr === 1'b1) begin
      a_wr_cnt++;
      if (sb.size() == 0) begin
        check("unexpected g_wr", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("g_adrs", 32'(a_if.g_adrs), 32'(e.adrs));
        check("g_data", 32'(a_if.g_data), 32'(e.data));
      end
    end
  end

  task automatic start_a(input logic [7:0] n);
    a_start   = 1'b1;
    a_stripes = n;
    tick();
    a_start = 1'b0;
    check("pu_start after start", 32'(a_pu_start), 32'(n != 0));
    check("busy after start", 32'(a_busy), 32'(n != 0));
    check("s_ready after start", 32'(a_if.s_ready), 32'(n != 0));
  endtask

  task automatic feed_col(input logic [15:0] base, input bit stall, input bit rd_glitch, input int cur_round);
    int got = 0;
    int cyc = 0;
    bit hs;
    while (got < ROWS && cyc < 40) begin
      a_if.s_valid = stall ? (cyc % 3 == 0) : 1'b1;
      a_if.s_data  = base + 16'(got);
      a_if.g_rd    = rd_glitch && (cyc == 1);
      hs = a_if.s_valid && a_if.s_ready;
      if (hs) begin
        sb.push_back('{adrs: AW'(exp_row), data: a_if.s_data});
        exp_row = (exp_row == ROWS - 1) ? 0 : exp_row + 1;
      end
      tick();
      cyc++;
      if (hs) got++;
      if (rd_glitch && cyc == 2) begin
        check("err after g_rd in FILL", 32'(a_err), 32'd1);
        check("round after g_rd in FILL", 32'(a_round), 32'(cur_round));
      end
    end
    a_if.s_valid = 1'b0;
    a_if.g_rd    = 1'b0;
    check("column fill bound", 32'(got), 32'(ROWS));
  endtask

  task automatic finish_col(input int cur_round, input bit last, input bit poke_start);
    check("handoff s_ready", 32'(a_if.s_ready), 32'd0);
    check("round stable", 32'(a_round), 32'(cur_round));
    if (poke_start) begin
      a_start   = 1'b1;
      a_stripes = 8'd1;
      tick();
      a_start = 1'b0;
      check("start in WAIT_RD pu_start", 32'(a_pu_start), 32'd0);
      check("start in WAIT_RD s_ready", 32'(a_if.s_ready), 32'd0);
      check("start in WAIT_RD round", 32'(a_round), 32'(cur_round));
    end
    a_if.g_rd = 1'b1;
    tick();
    a_if.g_rd = 1'b0;
    if (last) begin
      check("done after last g_rd", 32'(a_done), 32'd1);
      check("busy with done", 32'(a_busy), 32'd1);
      tick();
      check("done one cycle", 32'(a_done), 32'd0);
      check("busy after done", 32'(a_busy), 32'd0);
      check("s_ready idle", 32'(a_if.s_ready), 32'd0);
    end else begin
      check("s_ready after g_rd", 32'(a_if.s_ready), 32'd1);
      check("round after g_rd", 32'(a_round), 32'((cur_round + 1) % IMG_W_A));
      check("no done mid image", 32'(a_done), 32'd0);
    end
  endtask

  task automatic run_image(input int n_stripes, input bit stall_col1, input bit glitch_col0);
    int ncol = n_stripes * IMG_W_A;
    for (int c = 0; c < ncol; c++) begin
      check("round at column start", 32'(a_round), 32'(c % IMG_W_A));
      feed_col(16'h0100 * 16'(c + 1), stall_col1 && c == 1, glitch_col0 && c == 0, c % IMG_W_A);
      finish_col(c % IMG_W_A, c == ncol - 1, glitch_col0 && c == 0);
    end
    check("scoreboard drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_base;
    nrst = 1'b0;
    a_start = 1'b0; a_stripes = '0; b_start = 1'b0; b_stripes = '0;
    a_if.s_valid = 1'b0; a_if.s_data = '0; a_if.g_rd = 1'b0;
    b_if.s_valid = 1'b0; b_if.s_data = '0; b_if.g_rd = 1'b0;
    #12;
    check("reset s_ready", 32'(a_if.s_ready), 32'd0);
    check("reset busy", 32'(a_busy), 32'd0);
    check("reset round", 32'(a_round), 32'd0);
    nrst = 1'b1;
    tick();

    // dut_b: IMG_W=1, one stripe, back-to-back pixels.
    b_start = 1'b1; b_stripes = 8'd1;
    tick();
    b_start = 1'b0;
    check("b pu_start", 32'(b_pu_start), 32'd1);
    check("b s_ready", 32'(b_if.s_ready), 32'd1);
    for (int i = 0; i < ROWS; i++) begin
      b_if.s_valid = 1'b1;
      b_if.s_data  = 16'h0011 + 16'(i);
      tick();
      check("b g_wr", 32'(b_if.g_wr), 32'd1);
      check("b g_adrs", 32'(b_if.g_adrs), 32'(i));
      check("b g_data", 32'(b_if.g_data), 32'h11 + 32'(i));
    end
    check("b s_ready after column", 32'(b_if.s_ready), 32'd0);
    b_if.s_valid = 1'b0;
    tick();
    check("b g_wr idle in WAIT_RD", 32'(b_if.g_wr), 32'd0);
    b_if.g_rd = 1'b1;
    tick();
    b_if.g_rd = 1'b0;
    check("b done", 32'(b_done), 32'd1);
    check("b round", 32'(b_round), 32'd0);
    tick();
    check("b busy after done", 32'(b_busy), 32'd0);
    check("b done cleared", 32'(b_done), 32'd0);

    // Reset in the middle of a column after three writes.
    start_a(8'd2);
    for (int i = 0; i < 3; i++) begin
      a_if.s_valid = 1'b1;
      a_if.s_data  = 16'hA000 + 16'(i);
      sb.push_back('{adrs: AW'(i), data: a_if.s_data});
      tick();
    end
    a_if.s_valid = 1'b0;
    check("pre-reset g_adrs", 32'(a_if.g_adrs), 32'd2);
    #3;
    nrst = 1'b0;
    #1;
    check("async reset g_wr", 32'(a_if.g_wr), 32'd0);
    check("async reset g_adrs", 32'(a_if.g_adrs), 32'd0);
    check("async reset g_data", 32'(a_if.g_data), 32'd0);
    check("async reset s_ready", 32'(a_if.s_ready), 32'd0);
    check("async reset busy", 32'(a_busy), 32'd0);
    #3;
    nrst = 1'b1;
    exp_row = 0;
    for (int i = 0; i < 3; i++) tick();
    check("post-reset s_ready", 32'(a_if.s_ready), 32'd0);
    check("post-reset busy", 32'(a_busy), 32'd0);
    check("post-reset scoreboard", 32'(sb.size()), 32'd0);

    // Two stripes of three columns, with a stalled second column.
    wr_base = a_wr_cnt;
    start_a(8'd2);
    run_image(2, 1'b1, 1'b0);
    check("g_wr pulse count", 32'(a_wr_cnt - wr_base), 32'd30);

    // Protocol errors: g_rd in FILL and start in WAIT_RD.
    start_a(8'd1);
    check("err cleared at start", 32'(a_err), 32'd0);
    run_image(1, 1'b0, 1'b1);
    check("err sticky after image", 32'(a_err), 32'd1);
    start_a(8'd1);
    check("err cleared by new start", 32'(a_err), 32'd0);
    run_image(1, 1'b0, 1'b0);
    check("err clean image", 32'(a_err), 32'd0);

    // Zero stripes: done only.
    a_start = 1'b1; a_stripes = 8'd0;
    tick();
    a_start = 1'b0;
    check("zero stripes done", 32'(a_done), 32'd1);
    check("zero stripes pu_start", 32'(a_pu_start), 32'd0);
    check("zero stripes busy", 32'(a_busy), 32'd0);
    tick();
    check("zero stripes done cleared", 32'(a_done), 32'd0);
    check("zero stripes s_ready", 32'(a_if.s_ready), 32'd0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
